// File: rtl/count_sequence_checker.sv
// count_sequence_checker: monitors a free-running WIDTH-bit up-counter stream.
// Locks onto an incrementing sequence, then checks every valid sample against
// prev+1 (mod 2^WIDTH). It reports halfway and rollover milestones, counts
// errors, and completes with pass/fail once enough rollovers have been checked
// or the error limit is reached.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-high reset
//   valid         in   count_in is sampled on this edge
//   count_in      in   observed counter value [WIDTH-1:0]
//   locked        out  high while the checker is locked on the sequence
//   error_pulse   out  one-cycle pulse per mismatching locked sample
//   halfway_pulse out  one-cycle pulse on a correct locked sample == 2^(WIDTH-1)
//   err_count     out  saturating error count [7:0]
//   wrap_count    out  rollovers checked while locked [7:0]
//   done          out  sticky completion flag
//   pass          out  meaningful when done; 1 iff no errors were seen
//
// SIM_REPORT gates the simulation-only messages and the $finish on completion,
// so that an enclosing bench can keep running after the checker completes.

module count_sequence_checker #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_LEN        = 3,
  parameter int unsigned WRAPS_TO_FINISH = 1,
  parameter int unsigned MAX_ERRORS      = 15,
  parameter bit          SIM_REPORT      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             error_pulse,
  output logic             halfway_pulse,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count,
  output logic             done,
  output logic             pass
);

  localparam int unsigned CNT_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);
  localparam logic [WIDTH-1:0] HALF_VAL = WIDTH'(1 << (WIDTH - 1));

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOCK = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic               locked_q, locked_d;
  logic               error_pulse_q, error_pulse_d;
  logic               halfway_pulse_q, halfway_pulse_d;
  logic [7:0]         err_q, err_d;
  logic [7:0]         wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [WIDTH-1:0]   exp_val;
  logic               in_seq;
  logic [CNT_W-1:0]   match_inc;
  logic [7:0]         err_inc;
  logic [7:0]         wrap_inc;

  // Expected next value and saturating/incrementing helpers
  always_comb begin
    exp_val   = prev_q + WIDTH'(1);
    in_seq    = (count_in == exp_val);
    match_inc = match_q + CNT_W'(1);
    err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    wrap_inc  = wrap_q + 8'd1;
  end

  // Next-state and output computation
  always_comb begin
    state_d         = state_q;
    prev_d          = prev_q;
    match_d         = match_q;
    locked_d        = locked_q;
    error_pulse_d   = 1'b0;
    halfway_pulse_d = 1'b0;
    err_d           = err_q;
    wrap_d          = wrap_q;
    done_d          = done_q;
    pass_d          = pass_q;

    if (valid && (state_q != ST_DONE)) begin
      prev_d = count_in;
    end

    if (valid) begin
      case (state_q)
        ST_HUNT: begin
          match_d = CNT_W'(1);
          if (SYNC_LEN == 1) begin
            state_d  = ST_LOCK;
            locked_d = 1'b1;
          end else begin
            state_d  = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (in_seq) begin
            match_d = match_inc;
            if (match_inc >= CNT_W'(SYNC_LEN)) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end
          end else begin
            match_d = CNT_W'(1);
          end
        end

        ST_LOCK: begin
          if (in_seq) begin
            if (count_in == HALF_VAL) begin
              halfway_pulse_d = 1'b1;
            end
            if (count_in == '0) begin
              wrap_d = wrap_inc;
              if (wrap_inc == 8'(WRAPS_TO_FINISH)) begin
                state_d  = ST_DONE;
                locked_d = 1'b0;
                done_d   = 1'b1;
                pass_d   = (err_q == 8'd0);
              end
            end
          end else begin
            // Mismatch: error limit takes precedence over falling back to SYNC
            error_pulse_d = 1'b1;
            err_d         = err_inc;
            locked_d      = 1'b0;
            match_d       = CNT_W'(1);
            if (err_inc >= 8'(MAX_ERRORS)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b0;
            end else begin
              state_d = ST_SYNC;
            end
          end
        end

        default: begin
          // DONE ignores all inputs; counters stay frozen
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_HUNT;
      prev_q          <= '0;
      match_q         <= '0;
      locked_q        <= 1'b0;
      error_pulse_q   <= 1'b0;
      halfway_pulse_q <= 1'b0;
      err_q           <= 8'd0;
      wrap_q          <= 8'd0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      match_q         <= match_d;
      locked_q        <= locked_d;
      error_pulse_q   <= error_pulse_d;
      halfway_pulse_q <= halfway_pulse_d;
      err_q           <= err_d;
      wrap_q          <= wrap_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign locked        = locked_q;
  assign error_pulse   = error_pulse_q;
  assign halfway_pulse = halfway_pulse_q;
  assign err_count     = err_q;
  assign wrap_count    = wrap_q;
  assign done          = done_q;
  assign pass          = pass_q;

`ifndef SYNTHESIS
  // Simulation reporting; completion message and $finish fire once on DONE entry
  always @(posedge clk) begin
    if (SIM_REPORT && !rst) begin
      if (halfway_pulse_d) begin
        $display("[%m] Halfway point reached (count=%0d)", count_in);
      end
      if (wrap_d != wrap_q) begin
        $display("[%m] Rollover %0d checked", wrap_d);
      end
      if (error_pulse_d) begin
        $display("[%m] sequence error: expected %0d got %0d", exp_val, count_in);
      end
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
        if (err_d == 8'd0) begin
          $display("[%m] Checker PASS");
        end else begin
          $display("[%m] Checker FAIL (%0d errors)", err_d);
        end
        $finish;
      end
    end
  end
`endif

endmodule
